// File: rtl/fragment_tex_scheduler_pkg.sv
// Shared types for the fragment texture scheduler: the attribute record held
// while a texel is in flight, and the flush sequencer states.
package fragment_pkg;

  localparam int unsigned PKG_DATA_WIDTH = 32;
  localparam int unsigned PKG_VEC_SIZE   = 4;
  localparam int unsigned PKG_CORD_WIDTH = 10;

  typedef struct packed {
    logic signed [PKG_CORD_WIDTH-1:0]          x;
    logic signed [PKG_CORD_WIDTH-1:0]          y;
    logic [PKG_VEC_SIZE*PKG_DATA_WIDTH-1:0]    color;
  } frag_attr_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } sched_state_e;

endpackage

// File: rtl/frag_attr_fifo.sv
// Synchronous FIFO of fragment attributes; head is visible combinationally so
// the scheduler can capture it on the same cycle the texel arrives.
module frag_attr_fifo
  import fragment_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  frag_attr_t               push_data,
  input  logic                     pop,
  output frag_attr_t               pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  frag_attr_t    mem_q [DEPTH];
  frag_attr_t    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    push_ok  = push & (count_q != FULL_CNT);
    pop_ok   = pop & (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/fragment_tex_scheduler.sv
// Issues one texture fetch per rasterized fragment, parks the attributes until
// the in-order texel returns, then emits fragment + texel as one shader beat.
module fragment_tex_scheduler
  import fragment_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = PKG_DATA_WIDTH,
  parameter int unsigned VEC_SIZE        = PKG_VEC_SIZE,
  parameter int unsigned CORD_WIDTH      = PKG_CORD_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_frag_valid,
  output logic                                 o_frag_ready,
  input  logic signed [CORD_WIDTH-1:0]         i_frag_x,
  input  logic signed [CORD_WIDTH-1:0]         i_frag_y,
  input  logic [VEC_SIZE*DATA_WIDTH-1:0]       i_frag_color,
  input  logic [2*DATA_WIDTH-1:0]              i_frag_tex_coord,
  output logic                                 o_tex_req_valid,
  input  logic                                 i_tex_req_ready,
  output logic [2*DATA_WIDTH-1:0]              o_tex_req_coord,
  input  logic                                 i_tex_resp_valid,
  input  logic [VEC_SIZE*DATA_WIDTH-1:0]       i_tex_resp_texel,
  input  logic                                 i_flush,
  output logic                                 o_flush_done,
  output logic                                 o_shade_valid,
  output logic signed [CORD_WIDTH-1:0]         o_shade_x,
  output logic signed [CORD_WIDTH-1:0]         o_shade_y,
  output logic [VEC_SIZE*DATA_WIDTH-1:0]       o_shade_color,
  output logic [VEC_SIZE*DATA_WIDTH-1:0]       o_shade_texel,
  output logic [$clog2(MAX_OUTSTANDING):0]     o_outstanding,
  output logic                                 o_err
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  sched_state_e                  state_q, state_d;
  logic                          req_valid_q, req_valid_d;
  logic [2*DATA_WIDTH-1:0]       req_coord_q, req_coord_d;
  logic                          shade_valid_q, shade_valid_d;
  frag_attr_t                    shade_attr_q, shade_attr_d;
  logic [VEC_SIZE*DATA_WIDTH-1:0] shade_texel_q, shade_texel_d;
  logic                          err_q, err_d;

  logic [CW-1:0] count;
  frag_attr_t    push_attr, head_attr;
  logic          frag_ready, accept, fire, pop, flush_done;

  frag_attr_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_attr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_attr),
    .pop       (pop),
    .pop_data  (head_attr),
    .count     (count)
  );

  always_comb begin
    fire       = req_valid_q & i_tex_req_ready;
    frag_ready = (state_q == ST_RUN) && (count < MAX_CNT) && (!req_valid_q || i_tex_req_ready);
    accept     = i_frag_valid & frag_ready;
    pop        = i_tex_resp_valid & (count != '0);

    push_attr       = '0;
    push_attr.x     = i_frag_x;
    push_attr.y     = i_frag_y;
    push_attr.color = i_frag_color;

    // A fire and a new accept in the same cycle must leave the new request loaded.
    req_valid_d = req_valid_q;
    req_coord_d = req_coord_q;
    if (fire) begin
      req_valid_d = 1'b0;
      req_coord_d = '0;
    end
    if (accept) begin
      req_valid_d = 1'b1;
      req_coord_d = i_frag_tex_coord;
    end

    shade_valid_d = pop;
    shade_attr_d  = shade_attr_q;
    shade_texel_d = shade_texel_q;
    if (pop) begin
      shade_attr_d  = head_attr;
      shade_texel_d = i_tex_resp_texel;
    end

    err_d = err_q | (i_tex_resp_valid & (count == '0));
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((count == '0) && !req_valid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        flush_done = 1'b1;
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      req_valid_q   <= 1'b0;
      req_coord_q   <= '0;
      shade_valid_q <= 1'b0;
      shade_attr_q  <= '0;
      shade_texel_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_valid_q   <= req_valid_d;
      req_coord_q   <= req_coord_d;
      shade_valid_q <= shade_valid_d;
      shade_attr_q  <= shade_attr_d;
      shade_texel_q <= shade_texel_d;
      err_q         <= err_d;
    end
  end

  assign o_frag_ready    = frag_ready;
  assign o_tex_req_valid = req_valid_q;
  assign o_tex_req_coord = req_coord_q;
  assign o_flush_done    = flush_done;
  assign o_shade_valid   = shade_valid_q;
  assign o_shade_x       = shade_attr_q.x;
  assign o_shade_y       = shade_attr_q.y;
  assign o_shade_color   = shade_attr_q.color;
  assign o_shade_texel   = shade_texel_q;
  assign o_outstanding   = count;
  assign o_err           = err_q;

endmodule

// File: tb/tb_fragment_tex_scheduler.sv
// Scoreboard bench for fragment_tex_scheduler: stimulus pushes expected fetch
// coordinates and shade beats; a negedge monitor pops and compares them.
module tb_fragment_tex_scheduler;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_frag_valid;
  logic          o_frag_ready;
  logic signed [9:0] i_frag_x, i_frag_y;
  logic [127:0]  i_frag_color;
  logic [63:0]   i_frag_tex_coord;
  logic          o_tex_req_valid;
  logic          i_tex_req_ready;
  logic [63:0]   o_tex_req_coord;
  logic          i_tex_resp_valid;
  logic [127:0]  i_tex_resp_texel;
  logic          i_flush;
  logic          o_flush_done;
  logic          o_shade_valid;
  logic signed [9:0] o_shade_x, o_shade_y;
  logic [127:0]  o_shade_color, o_shade_texel;
  logic [2:0]    o_outstanding;
  logic          o_err;

  fragment_tex_scheduler #(
    .DATA_WIDTH      (32),
    .VEC_SIZE        (4),
    .CORD_WIDTH      (10),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_frag_valid     (i_frag_valid),
    .o_frag_ready     (o_frag_ready),
    .i_frag_x         (i_frag_x),
    .i_frag_y         (i_frag_y),
    .i_frag_color     (i_frag_color),
    .i_frag_tex_coord (i_frag_tex_coord),
    .o_tex_req_valid  (o_tex_req_valid),
    .i_tex_req_ready  (i_tex_req_ready),
    .o_tex_req_coord  (o_tex_req_coord),
    .i_tex_resp_valid (i_tex_resp_valid),
    .i_tex_resp_texel (i_tex_resp_texel),
    .i_flush          (i_flush),
    .o_flush_done     (o_flush_done),
    .o_shade_valid    (o_shade_valid),
    .o_shade_x        (o_shade_x),
    .o_shade_y        (o_shade_y),
    .o_shade_color    (o_shade_color),
    .o_shade_texel    (o_shade_texel),
    .o_outstanding    (o_outstanding),
    .o_err            (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [9:0] x;
    logic signed [9:0] y;
    logic [127:0]      c;
  } attr_t;

  typedef struct {
    attr_t        a;
    logic [127:0] t;
  } shade_t;

  attr_t       model_q   [$];
  shade_t      exp_shade [$];
  logic [63:0] exp_req   [$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] color_of(input int x);
    logic [31:0] xv;
    xv = x;
    return {xv, ~xv, xv + 32'h100, 32'hC0FFEE00};
  endfunction

  function automatic logic [127:0] texel_of(input logic [31:0] n);
    return {n, n ^ 32'h0000FFFF, n + 32'd1, 32'h7E7E0000 | n};
  endfunction

  task automatic drive_frag(input int x, input int y, input logic [63:0] tc);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    i_frag_valid     = 1'b1;
    i_frag_x         = xv[9:0];
    i_frag_y         = yv[9:0];
    i_frag_color     = color_of(x);
    i_frag_tex_coord = tc;
  endtask

  task automatic record_accept();
    attr_t a;
    a.x = i_frag_x;
    a.y = i_frag_y;
    a.c = i_frag_color;
    model_q.push_back(a);
    exp_req.push_back(i_frag_tex_coord);
  endtask

  task automatic drive_resp(input logic [31:0] n);
    shade_t s;
    i_tex_resp_valid = 1'b1;
    i_tex_resp_texel = texel_of(n);
    if (model_q.size() > 0) begin
      s.a = model_q.pop_front();
      s.t = texel_of(n);
      exp_shade.push_back(s);
    end
  endtask

  task automatic do_accept(input int x, input int y, input logic [63:0] tc);
    drive_frag(x, y, tc);
    chk("frag_ready_on_accept", o_frag_ready, 1'b1);
    record_accept();
    tick();
    i_frag_valid = 1'b0;
  endtask

  task automatic resp(input logic [31:0] n);
    drive_resp(n);
    tick();
    i_tex_resp_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_shade_valid) begin
        if (exp_shade.size() == 0) begin
          total_cnt++;
          $display("FAIL shade_unexpected: got x=%0d with nothing expected", o_shade_x);
        end else begin
          shade_t s;
          s = exp_shade.pop_front();
          chk("shade_x", o_shade_x, s.a.x);
          chk("shade_y", o_shade_y, s.a.y);
          chk("shade_color", o_shade_color, s.a.c);
          chk("shade_texel", o_shade_texel, s.t);
        end
      end
      if (o_tex_req_valid && i_tex_req_ready) begin
        if (exp_req.size() == 0) begin
          total_cnt++;
          $display("FAIL req_unexpected: got coord %0h with nothing expected", o_tex_req_coord);
        end else begin
          chk("req_coord", o_tex_req_coord, exp_req.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    i_frag_valid = 1'b0;
    i_frag_x = '0;
    i_frag_y = '0;
    i_frag_color = '0;
    i_frag_tex_coord = '0;
    i_tex_req_ready = 1'b1;
    i_tex_resp_valid = 1'b0;
    i_tex_resp_texel = '0;
    i_flush = 1'b0;
    tick();
    tick();
    chk("rst_req_valid", o_tex_req_valid, 1'b0);
    chk("rst_shade_valid", o_shade_valid, 1'b0);
    chk("rst_flush_done", o_flush_done, 1'b0);
    chk("rst_outstanding", o_outstanding, 3'd0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_shade_texel", o_shade_texel, 128'd0);
    rst = 1'b0;
    tick();

    // single fragment, texel two cycles after the fetch fires
    do_accept(5, -7, {32'h10, 32'h20});
    chk("single_req_coord", o_tex_req_coord, {32'h10, 32'h20});
    tick();
    tick();
    resp(32'hAA);
    chk("single_shade_valid", o_shade_valid, 1'b1);
    tick();
    chk("single_outstanding", o_outstanding, 3'd0);
    chk("single_shade_hold_x", o_shade_x, 10'sd5);

    // fill to MAX with no responses
    for (int i = 0; i < 4; i++) do_accept(10 + i, i, 64'h1000 + 64'(i));
    drive_frag(14, 0, 64'h2000);
    chk("full_ready", o_frag_ready, 1'b0);
    chk("full_outstanding", o_outstanding, 3'd4);
    i_frag_valid = 1'b0;
    resp(32'h10);
    chk("full_ready_after_pop", o_frag_ready, 1'b1);
    chk("full_outstanding_after_pop", o_outstanding, 3'd3);
    resp(32'h11);
    resp(32'h12);
    resp(32'h13);
    tick();

    // request backpressure
    i_tex_req_ready = 1'b0;
    do_accept(20, 3, {32'h33, 32'h44});
    for (int i = 0; i < 5; i++) begin
      drive_frag(21, 0, 64'h5555);
      chk("bp_frag_ready", o_frag_ready, 1'b0);
      chk("bp_req_valid", o_tex_req_valid, 1'b1);
      chk("bp_req_coord", o_tex_req_coord, {32'h33, 32'h44});
      tick();
    end
    i_frag_valid = 1'b0;
    i_tex_req_ready = 1'b1;
    tick();
    tick();
    chk("bp_req_cleared", o_tex_req_valid, 1'b0);
    resp(32'h20);
    tick();

    // ordering with a simultaneous accept and pop
    do_accept(1, 0, 64'h101);
    do_accept(2, 0, 64'h102);
    do_accept(3, 0, 64'h103);
    drive_frag(4, 0, 64'h104);
    chk("ord_ready", o_frag_ready, 1'b1);
    drive_resp(32'hF1);
    record_accept();
    tick();
    i_frag_valid = 1'b0;
    i_tex_resp_valid = 1'b0;
    chk("ord_outstanding_kept", o_outstanding, 3'd3);
    resp(32'hF2);
    resp(32'hF3);
    resp(32'hF4);
    tick();

    // flush with nothing outstanding
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush0_drain_done", o_flush_done, 1'b0);
    chk("flush0_drain_ready", o_frag_ready, 1'b0);
    tick();
    chk("flush0_done", o_flush_done, 1'b1);
    tick();
    chk("flush0_done_pulse", o_flush_done, 1'b0);
    chk("flush0_run_ready", o_frag_ready, 1'b1);

    // flush with two outstanding
    do_accept(30, 1, 64'h301);
    do_accept(31, 2, 64'h302);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush2_ready", o_frag_ready, 1'b0);
    tick();
    chk("flush2_ready_hold", o_frag_ready, 1'b0);
    chk("flush2_no_done", o_flush_done, 1'b0);
    resp(32'h30);
    chk("flush2_ready_mid", o_frag_ready, 1'b0);
    resp(32'h31);
    chk("flush2_done_early", o_flush_done, 1'b0);
    tick();
    chk("flush2_done", o_flush_done, 1'b1);
    chk("flush2_done_ready", o_frag_ready, 1'b0);
    tick();
    chk("flush2_done_pulse", o_flush_done, 1'b0);
    do_accept(32, 3, 64'h303);
    resp(32'h32);
    tick();

    // stray response with nothing outstanding
    chk("err_before", o_err, 1'b0);
    resp(32'hBAD);
    chk("err_set", o_err, 1'b1);
    chk("err_outstanding", o_outstanding, 3'd0);
    tick();
    chk("err_sticky", o_err, 1'b1);

    // reset mid-stream
    do_accept(40, 0, 64'h401);
    do_accept(41, 0, 64'h402);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_q.delete();
    exp_req.delete();
    chk("rst2_err", o_err, 1'b0);
    chk("rst2_outstanding", o_outstanding, 3'd0);
    chk("rst2_req_valid", o_tex_req_valid, 1'b0);
    chk("rst2_req_coord", o_tex_req_coord, 64'd0);
    chk("rst2_shade_x", o_shade_x, 10'sd0);
    chk("rst2_shade_color", o_shade_color, 128'd0);
    resp(32'h99);
    chk("rst2_late_err", o_err, 1'b1);
    chk("rst2_late_outstanding", o_outstanding, 3'd0);

    w = 0;
    while ((exp_shade.size() != 0 || exp_req.size() != 0) && w < 20) begin
      tick();
      w++;
    end
    chk("sb_shade_drained", 128'(exp_shade.size()), 128'd0);
    chk("sb_req_drained", 128'(exp_req.size()), 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
